// File: rtl/seq_detect_ctrl.sv
// Run controller for a programmable symbol-sequence detector with hit counting.
// Optional idle timeout in SCAN is enabled by defining SEQ_CTRL_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start; pattern writable; results held
// SCAN  | accepting symbols and tracking the matched prefix
// DONE  | one-cycle end-of-run pulse, then back to IDLE
module seq_detect_ctrl #(
    parameter int SYM_W   = 3,
    parameter int PAT_LEN = 8,
    parameter int IDX_W   = 3,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_we_i,
    input  logic [IDX_W-1:0] cfg_addr_i,
    input  logic [SYM_W-1:0] cfg_wdata_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] hit_target_i,
    input  logic             in_valid_i,
    input  logic [SYM_W-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             busy_o,
    output logic [IDX_W-1:0] match_idx_o,
    output logic             sequence_found_o,
    output logic [CNT_W-1:0] hit_count_o,
    output logic             done_o,
    output logic             timed_out_o
);

    if (PAT_LEN < 2 || (PAT_LEN & (PAT_LEN - 1)) != 0 || (1 << IDX_W) != PAT_LEN || TIMEOUT < 1)
    begin : g_bad_param
        $error("seq_detect_ctrl: inconsistent PAT_LEN/IDX_W/TIMEOUT");
    end

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [SYM_W-1:0] pat_q [PAT_LEN];
    logic [IDX_W-1:0] match_idx_q, match_idx_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             found_q, found_d;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    assign in_ready_o = (state_q == S_SCAN) && !abort_i;
    assign accept     = in_valid_i && in_ready_o;
    assign cnt_inc    = (hit_count_q == '1) ? hit_count_q : hit_count_q + CNT_W'(1);

`ifdef SEQ_CTRL_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timed_out_q, timed_out_d;
    assign timed_out_o = timed_out_q;
`else
    assign timed_out_o = 1'b0;
`endif

    // Pattern is frozen for the whole run; a write alongside start lands first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PAT_LEN; i++) pat_q[i] <= '0;
        end else if (cfg_we_i && state_q == S_IDLE) begin
            pat_q[cfg_addr_i] <= cfg_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            match_idx_q <= '0;
            hit_count_q <= '0;
            target_q    <= '0;
            found_q     <= 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
            idle_q      <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            match_idx_q <= match_idx_d;
            hit_count_q <= hit_count_d;
            target_q    <= target_d;
            found_q     <= found_d;
`ifdef SEQ_CTRL_TIMEOUT_EN
            idle_q      <= idle_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        match_idx_d = match_idx_q;
        hit_count_d = hit_count_q;
        target_d    = target_q;
        found_d     = 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
        idle_d      = idle_q;
        timed_out_d = timed_out_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_SCAN;
                    match_idx_d = '0;
                    hit_count_d = '0;
                    target_d    = hit_target_i;
`ifdef SEQ_CTRL_TIMEOUT_EN
                    idle_d      = '0;
                    timed_out_d = 1'b0;
`endif
                end
            end
            S_SCAN: begin
                if (abort_i) begin
                    state_d = S_DONE;
                end else if (accept) begin
`ifdef SEQ_CTRL_TIMEOUT_EN
                    idle_d = '0;
`endif
                    if (in_data_i == pat_q[match_idx_q]) begin
                        if (match_idx_q == IDX_W'(PAT_LEN - 1)) begin
                            // Non-overlapping: restart from index 0 after a hit.
                            match_idx_d = '0;
                            hit_count_d = cnt_inc;
                            found_d     = 1'b1;
                            if (target_q != '0 && cnt_inc == target_q) state_d = S_DONE;
                        end else begin
                            match_idx_d = match_idx_q + IDX_W'(1);
                        end
                    end else begin
                        match_idx_d = (in_data_i == pat_q[0]) ? IDX_W'(1) : '0;
                    end
                end else begin
`ifdef SEQ_CTRL_TIMEOUT_EN
                    idle_d = idle_q + IDLE_W'(1);
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        state_d     = S_DONE;
                        timed_out_d = 1'b1;
                    end
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = (state_q == S_DONE);
    assign match_idx_o      = match_idx_q;
    assign hit_count_o      = hit_count_q;
    assign sequence_found_o = found_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl; timeout steps run only
// when SEQ_CTRL_TIMEOUT_EN is defined.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [2:0] cfg_wdata;
    logic       start;
    logic       abort;
    logic [7:0] hit_target;
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_ready;
    logic       busy;
    logic [2:0] match_idx;
    logic       sequence_found;
    logic [7:0] hit_count;
    logic       done;
    logic       timed_out;

    int checks = 0;
    int errors = 0;

    logic [2:0] pat [8] = '{3'd1, 3'd5, 3'd6, 3'd0, 3'd6, 3'd6, 3'd3, 3'd5};

    seq_detect_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cfg_we_i        (cfg_we),
        .cfg_addr_i      (cfg_addr),
        .cfg_wdata_i     (cfg_wdata),
        .start_i         (start),
        .abort_i         (abort),
        .hit_target_i    (hit_target),
        .in_valid_i      (in_valid),
        .in_data_i       (in_data),
        .in_ready_o      (in_ready),
        .busy_o          (busy),
        .match_idx_o     (match_idx),
        .sequence_found_o(sequence_found),
        .hit_count_o     (hit_count),
        .done_o          (done),
        .timed_out_o     (timed_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [2:0] d);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic program_pattern();
        for (int i = 0; i < 8; i++) write_entry(i, pat[i]);
    endtask

    task automatic do_start(input logic [7:0] tgt);
        start = 1'b1; hit_target = tgt;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_idx", match_idx, 0);
        chk("start_hits", hit_count, 0);
    endtask

    task automatic send(input logic [2:0] sym, input logic [2:0] exp_idx, input string tag);
        in_valid = 1'b1; in_data = sym;
        tick();
        chk(tag, match_idx, exp_idx);
    endtask

    task automatic send_pattern(input string tag);
        for (int i = 0; i < 8; i++) send(pat[i], (i == 7) ? 3'd0 : 3'(i + 1), tag);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; abort = 1'b0; hit_target = '0; in_valid = 1'b0; in_data = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_idx", match_idx, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_found", sequence_found, 0);
        chk("rst_done", done, 0);
        chk("rst_tmo", timed_out, 0);
        chk("rst_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();

        // Single-hit run
        program_pattern();
        do_start(8'd1);
        chk("scan_ready", in_ready, 1);
        send_pattern("t1_idx");
        in_valid = 1'b0;
        chk("t1_found", sequence_found, 1);
        chk("t1_done", done, 1);
        chk("t1_hits", hit_count, 1);
        tick();
        chk("t1_busy_drop", busy, 0);
        chk("t1_found_pulse", sequence_found, 0);
        chk("t1_done_pulse", done, 0);
        chk("t1_hits_hold", hit_count, 1);

        // Mismatch re-tests the failing symbol as a new start
        do_start(8'd1);
        send(3'd1, 3'd1, "t2_idx0");
        send(3'd1, 3'd1, "t2_retest");
        for (int i = 1; i < 8; i++) send(pat[i], (i == 7) ? 3'd0 : 3'(i + 1), "t2_idx");
        in_valid = 1'b0;
        chk("t2_found", sequence_found, 1);
        chk("t2_done", done, 1);
        chk("t2_hits", hit_count, 1);
        tick();

        // Two hits back-to-back
        do_start(8'd2);
        send_pattern("t3a_idx");
        chk("t3_found1", sequence_found, 1);
        chk("t3_nodone1", done, 0);
        chk("t3_hits1", hit_count, 1);
        send(pat[0], 3'd1, "t3b_first");
        chk("t3_found_gap", sequence_found, 0);
        for (int i = 1; i < 8; i++) send(pat[i], (i == 7) ? 3'd0 : 3'(i + 1), "t3b_idx");
        in_valid = 1'b0;
        chk("t3_found2", sequence_found, 1);
        chk("t3_done2", done, 1);
        chk("t3_hits2", hit_count, 2);
        tick();
        chk("t3_idle", busy, 0);

        // Abort with target 0
        do_start(8'd0);
        for (int i = 0; i < 3; i++) send(pat[i], 3'(i + 1), "t4_idx");
        abort = 1'b1; in_valid = 1'b1; in_data = pat[3];
        #1;
        chk("t4_ready_abort", in_ready, 0);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_idx_held", match_idx, 3);
        chk("t4_hits", hit_count, 0);
        chk("t4_found", sequence_found, 0);
        tick();
        chk("t4_idle", busy, 0);
        chk("t4_idx_idle", match_idx, 3);

        // Write while busy is ignored
        do_start(8'd1);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 3'd7;
        send(3'd1, 3'd1, "t5_busy_write");
        cfg_we = 1'b0;
        for (int i = 1; i < 8; i++) send(pat[i], (i == 7) ? 3'd0 : 3'(i + 1), "t5_idx");
        in_valid = 1'b0;
        chk("t5_found", sequence_found, 1);
        chk("t5_done", done, 1);
        tick();

        // Write together with start lands and is used by the scan
        cfg_we = 1'b1; cfg_addr = 3'd7; cfg_wdata = 3'd2;
        do_start(8'd1);
        cfg_we = 1'b0;
        for (int i = 0; i < 7; i++) send(pat[i], 3'(i + 1), "t6_idx");
        send(3'd2, 3'd0, "t6_last");
        in_valid = 1'b0;
        chk("t6_found", sequence_found, 1);
        chk("t6_done", done, 1);
        tick();
        write_entry(7, pat[7]);

`ifdef SEQ_CTRL_TIMEOUT_EN
        do_start(8'd0);
        for (int i = 0; i < 15; i++) tick();
        chk("t7_not_yet", done, 0);
        tick();
        chk("t7_done", done, 1);
        chk("t7_tmo", timed_out, 1);
        tick();
        chk("t7_idle", busy, 0);
        chk("t7_sticky", timed_out, 1);
        do_start(8'd0);
        chk("t7_cleared", timed_out, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t7_abort_done", done, 1);
        chk("t7_abort_tmo", timed_out, 0);
        tick();
`else
        do_start(8'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("t7_no_tmo_busy", busy, 1);
        chk("t7_no_tmo_flag", timed_out, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t7_abort_done", done, 1);
        tick();
`endif

        // Asynchronous reset mid-scan
        do_start(8'd1);
        for (int i = 0; i < 5; i++) send(pat[i], 3'(i + 1), "t8_idx");
        rst_n = 1'b0;
        #1;
        chk("t8_busy", busy, 0);
        chk("t8_idx", match_idx, 0);
        chk("t8_ready", in_ready, 0);
        chk("t8_hits", hit_count, 0);
        chk("t8_done", done, 0);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        do_start(8'd1);
        for (int i = 0; i < 8; i++) send(3'd0, (i == 7) ? 3'd0 : 3'(i + 1), "t8_zero_pat");
        in_valid = 1'b0;
        chk("t8_zero_found", sequence_found, 1);
        tick();
        program_pattern();
        do_start(8'd1);
        send_pattern("t8_rerun");
        in_valid = 1'b0;
        chk("t8_rerun_found", sequence_found, 1);
        chk("t8_rerun_done", done, 1);
        chk("t8_rerun_hits", hit_count, 1);
        tick();
        chk("t8_rerun_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
